avg_feature_requester: RTL

AVG_FEATURE_REQUESTER -- requirements
Module: avg_feature_requester

---
 rtl/avg_feature_requester_if.sv | 49 ++++
 rtl/avg_feature_requester.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/avg_feature_requester_if.sv
`default_nettype none
// ============================================================================
//  Module   : avg_feature_requester_if
//  Brief    : Host request/result bundle plus the divider handshake for the
//             flow-feature requester. The master side is the requester, the
//             slave side is whoever drives stats and answers divisions.
//  Revision : 1.0 - initial release
// ============================================================================
interface avg_feature_requester_if;
    // Host request and flow statistics
    logic       start;
    logic [7:0] pkt_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] dur;
    logic [7:0] iat_sum;

    // Divider handshake
    logic [7:0] div_a;
    logic [7:0] div_b;
    logic       div_vld;
    logic [7:0] div_quo;
    logic [7:0] div_rem;
    logic       div_ack;

    // Status and results
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] feat_pps;
    logic [7:0] feat_bps;
    logic [7:0] feat_size;
    logic [7:0] feat_iat;
    logic [3:0] zdiv;

    modport master (
        input  start, pkt_cnt, byte_cnt, dur, iat_sum,
        input  div_quo, div_rem, div_ack,
        output div_a, div_b, div_vld,
        output busy, done, err, feat_pps, feat_bps, feat_size, feat_iat, zdiv
    );

    modport slave (
        output start, pkt_cnt, byte_cnt, dur, iat_sum,
        output div_quo, div_rem, div_ack,
        input  div_a, div_b, div_vld,
        input  busy, done, err, feat_pps, feat_bps, feat_size, feat_iat, zdiv
    );
endinterface
`default_nettype wire

// File: rtl/avg_feature_requester.sv
`default_nettype none
// ============================================================================
//  Module   : avg_feature_requester
//  Brief    : Computes four flow features (pps, bps, size, iat) by issuing
//             sequential requests to an external divider. Zero divisors are
//             flagged without a division; a stalled divider aborts with err.
//  Revision : 1.0 - initial release
// ============================================================================
module avg_feature_requester #(
    parameter int TIMEOUT = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    avg_feature_requester_if.master bus
);

    // Counter only has to reach TIMEOUT-1: the last WAIT cycle is the compare hit
    localparam int                   c_CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_NEXT  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;

    logic [7:0]         r_pkt;
    logic [7:0]         r_byte;
    logic [7:0]         r_dur;
    logic [7:0]         r_iat;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_div_a;
    logic [7:0]         r_div_b;
    logic               r_div_vld;
    logic               r_err;
    logic [3:0]         r_zdiv;
    logic [3:0][7:0]    r_feat;

    logic [7:0]         w_num;
    logic [7:0]         w_den;
    logic               w_den_zero;
    logic               w_timeout;
    logic               w_unused_rem;

    // The remainder is part of the divider bus but carries nothing we need
    assign w_unused_rem = ^bus.div_rem;

    // Dividend/divisor pair for the feature currently being worked on
    always_comb begin
        w_num = 8'h00;
        w_den = 8'h00;
        case (r_idx)
            2'd0:    begin w_num = r_pkt;  w_den = r_dur; end
            2'd1:    begin w_num = r_byte; w_den = r_dur; end
            2'd2:    begin w_num = r_byte; w_den = r_pkt; end
            default: begin w_num = r_iat;  w_den = r_pkt; end
        endcase
    end

    assign w_den_zero = (w_den == 8'h00);
    assign w_timeout  = (r_cnt == c_CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; ack wins over timeout on the final WAIT cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.start) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = w_den_zero ? c_ST_NEXT : c_ST_WAIT;
            c_ST_WAIT: begin
                if (bus.div_ack) begin
                    w_state_nxt = c_ST_NEXT;
                end else if (w_timeout) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_NEXT:  w_state_nxt = (r_idx == 2'd3) ? c_ST_DONE : c_ST_ISSUE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Datapath: stat latch, divider request, result capture and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pkt     <= 8'h00;
            r_byte    <= 8'h00;
            r_dur     <= 8'h00;
            r_iat     <= 8'h00;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_div_a   <= 8'h00;
            r_div_b   <= 8'h00;
            r_div_vld <= 1'b0;
            r_err     <= 1'b0;
            r_zdiv    <= 4'h0;
            r_feat    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_pkt  <= bus.pkt_cnt;
                        r_byte <= bus.byte_cnt;
                        r_dur  <= bus.dur;
                        r_iat  <= bus.iat_sum;
                        r_idx  <= 2'd0;
                        r_err  <= 1'b0;
                        r_zdiv <= 4'h0;
                        r_feat <= '0;
                    end
                end
                c_ST_ISSUE: begin
                    if (w_den_zero) begin
                        r_feat[r_idx] <= 8'hFF;
                        r_zdiv[r_idx] <= 1'b1;
                    end else begin
                        r_div_a   <= w_num;
                        r_div_b   <= w_den;
                        r_div_vld <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                c_ST_WAIT: begin
                    if (bus.div_ack) begin
                        r_feat[r_idx] <= bus.div_quo;
                        r_div_vld     <= 1'b0;
                        r_div_a       <= 8'h00;
                        r_div_b       <= 8'h00;
                    end else if (w_timeout) begin
                        r_err     <= 1'b1;
                        r_div_vld <= 1'b0;
                        r_div_a   <= 8'h00;
                        r_div_b   <= 8'h00;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_NEXT: begin
                    if (r_idx != 2'd3) begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.div_a     = r_div_a;
    assign bus.div_b     = r_div_b;
    assign bus.div_vld   = r_div_vld;
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.done      = (r_state == c_ST_DONE);
    assign bus.err       = r_err;
    assign bus.zdiv      = r_zdiv;
    assign bus.feat_pps  = r_feat[0];
    assign bus.feat_bps  = r_feat[1];
    assign bus.feat_size = r_feat[2];
    assign bus.feat_iat  = r_feat[3];

endmodule
`default_nettype wire
